// File: rtl/wptr_full_ctrl_pkg.sv
// Shared constants and Gray/binary helpers for the write-side FIFO pointer logic.
// Optional feature macro: WPTR_LEVEL_EN (occupancy level + programmable full).
package wptr_full_ctrl_pkg;
  localparam int ADDRSIZE_DEF         = 4;
  localparam int DEPTH_DEF            = 1 << ADDRSIZE_DEF;
  localparam int PROG_FULL_THRESH_DEF = 12;

  // Binary to Gray: each bit XORed with its upper neighbour.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary: running XOR from the MSB down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/wptr_gray2bin.sv
// Parameterized Gray to binary converter: bin[i] is the XOR of gray[W-1:i].
module wptr_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  // One XOR-reduction per output bit; purely combinational.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/flag controller for a dual-clock FIFO.
// Produces the memory write address, Gray write pointer for the read-domain
// synchronizer, registered full / almost-full, and a sticky overflow flag.
// Optional feature macro: WPTR_LEVEL_EN adds wlevel and wprog_full.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int ADDRSIZE         = ADDRSIZE_DEF,
  parameter int PROG_FULL_THRESH = PROG_FULL_THRESH_DEF
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic                woverflow
`ifdef WPTR_LEVEL_EN
  ,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wprog_full
`endif
);
  localparam int W     = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;

  // Reject out-of-range configurations at elaboration.
  if (ADDRSIZE < 2) begin : g_bad_addrsize
    $error("ADDRSIZE must be at least 2");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("PROG_FULL_THRESH out of range 1..2**ADDRSIZE");
  end

  logic [W-1:0] wbin;
  logic [W-1:0] wbinnext, wbinnextp1;
  logic [W-1:0] wgraynext, wgraynextp1;
  logic [W-1:0] rfullcmp;

  // Next-pointer arithmetic and the full-compare pattern (top two Gray bits inverted).
  always_comb begin
    wen         = winc & ~wfull;
    wbinnext    = wbin + {{ADDRSIZE{1'b0}}, wen};
    wbinnextp1  = wbinnext + {{ADDRSIZE{1'b0}}, 1'b1};
    wgraynext   = W'(bin2gray(32'(wbinnext)));
    wgraynextp1 = W'(bin2gray(32'(wbinnextp1)));
    rfullcmp    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // Pointer, flag and sticky-overflow registers; overflow set beats clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      awfull    <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= (wgraynext == rfullcmp);
      awfull <= (wgraynextp1 == rfullcmp);
      if (winc && wfull)  woverflow <= 1'b1;
      else if (wovf_clr)  woverflow <= 1'b0;
    end
  end

`ifdef WPTR_LEVEL_EN
  logic [W-1:0] rbin_s;
  logic [W-1:0] level_next;

  wptr_gray2bin #(.W(W)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  // Occupancy from the post-write pointer and the synchronized read pointer.
  always_comb begin
    level_next = wbinnext - rbin_s;
  end

  // Registered level and programmable-full flag.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wlevel     <= '0;
      wprog_full <= 1'b0;
    end else begin
      wlevel     <= level_next;
      wprog_full <= (level_next >= W'(PROG_FULL_THRESH));
    end
  end
`endif
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl (ADDRSIZE=4, THRESH=12).
module tb_wptr_full_ctrl;
  logic       wclk = 1'b0;
  logic       wrst, winc, wovf_clr;
  logic [4:0] wq2_rptr;
  logic       wen, wfull, awfull, woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr;
`ifdef WPTR_LEVEL_EN
  logic [4:0] wlevel;
  logic       wprog_full;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wptr_full_ctrl #(.ADDRSIZE(4), .PROG_FULL_THRESH(12)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .winc      (winc),
    .wq2_rptr  (wq2_rptr),
    .wovf_clr  (wovf_clr),
    .wen       (wen),
    .waddr     (waddr),
    .wptr      (wptr),
    .wfull     (wfull),
    .awfull    (awfull),
    .woverflow (woverflow)
`ifdef WPTR_LEVEL_EN
    ,
    .wlevel    (wlevel),
    .wprog_full(wprog_full)
`endif
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1; winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = '0;
    tick(); tick();
    n_cmp++; if (wptr !== 5'd0)    begin n_err++; $display("FAIL reset_wptr got=%b exp=00000", wptr); end
    n_cmp++; if (waddr !== 4'd0)   begin n_err++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    n_cmp++; if (wfull !== 1'b0)   begin n_err++; $display("FAIL reset_wfull got=%b exp=0", wfull); end
    n_cmp++; if (awfull !== 1'b0)  begin n_err++; $display("FAIL reset_awfull got=%b exp=0", awfull); end
    n_cmp++; if (woverflow !== 1'b0) begin n_err++; $display("FAIL reset_wovf got=%b exp=0", woverflow); end
`ifdef WPTR_LEVEL_EN
    n_cmp++; if (wlevel !== 5'd0)  begin n_err++; $display("FAIL reset_wlevel got=%0d exp=0", wlevel); end
    n_cmp++; if (wprog_full !== 1'b0) begin n_err++; $display("FAIL reset_progfull got=%b exp=0", wprog_full); end
`endif
    wrst = 1'b0; winc = 1'b0;
  endtask

  task automatic test_fill();
    wq2_rptr = '0;
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++; if (wen !== 1'b1) begin n_err++; $display("FAIL fill_wen[%0d] got=%b exp=1", i, wen); end
      n_cmp++; if (waddr !== 4'(i - 1)) begin n_err++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, i - 1); end
      tick();
      n_cmp++; if (awfull !== (i == 15)) begin n_err++; $display("FAIL fill_awfull[%0d] got=%b exp=%b", i, awfull, i == 15); end
      n_cmp++; if (wfull !== (i == 16))  begin n_err++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, wfull, i == 16); end
`ifdef WPTR_LEVEL_EN
      n_cmp++; if (wlevel !== 5'(i)) begin n_err++; $display("FAIL fill_wlevel[%0d] got=%0d exp=%0d", i, wlevel, i); end
      n_cmp++; if (wprog_full !== (i >= 12)) begin n_err++; $display("FAIL fill_progfull[%0d] got=%b exp=%b", i, wprog_full, i >= 12); end
`endif
    end
    winc = 1'b0;
    n_cmp++; if (wptr !== 5'b11000) begin n_err++; $display("FAIL fill_wptr got=%b exp=11000", wptr); end
  endtask

  task automatic test_overflow();
    winc = 1'b1;
    #1;
    n_cmp++; if (wen !== 1'b0)   begin n_err++; $display("FAIL ovf_wen got=%b exp=0", wen); end
    tick();
    n_cmp++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", woverflow); end
    n_cmp++; if (waddr !== 4'd0) begin n_err++; $display("FAIL ovf_waddr got=%0d exp=0", waddr); end
    n_cmp++; if (wptr !== 5'b11000) begin n_err++; $display("FAIL ovf_wptr got=%b exp=11000", wptr); end
    wovf_clr = 1'b1;
    tick();
    n_cmp++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clr got=%b exp=1", woverflow); end
    winc = 1'b0;
    tick();
    n_cmp++; if (woverflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", woverflow); end
    wovf_clr = 1'b0;
  endtask

  task automatic test_release();
    wq2_rptr = 5'b00001;
    tick();
    n_cmp++; if (wfull !== 1'b0)  begin n_err++; $display("FAIL rel_wfull got=%b exp=0", wfull); end
    n_cmp++; if (awfull !== 1'b1) begin n_err++; $display("FAIL rel_awfull got=%b exp=1", awfull); end
`ifdef WPTR_LEVEL_EN
    n_cmp++; if (wlevel !== 5'd15) begin n_err++; $display("FAIL rel_wlevel got=%0d exp=15", wlevel); end
`endif
  endtask

  task automatic test_wrap();
    logic [4:0] prev, rb;
    wrst = 1'b1; wq2_rptr = '0; tick(); wrst = 1'b0;
    n_cmp++; if (wptr !== 5'd0) begin n_err++; $display("FAIL wrap_reset_wptr got=%b exp=00000", wptr); end
    prev = wptr;
    winc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rb = (i >= 3) ? 5'(i - 3) : 5'd0;
      wq2_rptr = g5(rb);
      #1;
      n_cmp++; if (waddr !== 4'(i)) begin n_err++; $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", i, waddr, i % 16); end
      tick();
      n_cmp++; if (wptr !== g5(5'(i + 1))) begin n_err++; $display("FAIL wrap_wptr[%0d] got=%b exp=%b", i, wptr, g5(5'(i + 1))); end
      n_cmp++; if ($countones(wptr ^ prev) != 1) begin n_err++; $display("FAIL wrap_gray_step[%0d] got=%b prev=%b exp=one-bit change", i, wptr, prev); end
      n_cmp++; if (wfull !== 1'b0 || awfull !== 1'b0) begin n_err++; $display("FAIL wrap_flags[%0d] got=%b%b exp=00", i, wfull, awfull); end
`ifdef WPTR_LEVEL_EN
      n_cmp++; if (wlevel !== 5'(i + 1) - rb) begin n_err++; $display("FAIL wrap_wlevel[%0d] got=%0d exp=%0d", i, wlevel, 5'(i + 1) - rb); end
`endif
      prev = wptr;
    end
    winc = 1'b0;
  endtask

`ifdef WPTR_LEVEL_EN
  task automatic test_prog_full();
    wrst = 1'b1; wq2_rptr = '0; tick(); wrst = 1'b0;
    winc = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_cmp++; if (wprog_full !== (i == 12)) begin n_err++; $display("FAIL pf_write[%0d] got=%b exp=%b", i, wprog_full, i == 12); end
    end
    winc = 1'b0;
    wq2_rptr = 5'b00001;
    tick();
    n_cmp++; if (wprog_full !== 1'b0) begin n_err++; $display("FAIL pf_release got=%b exp=0", wprog_full); end
    n_cmp++; if (wlevel !== 5'd11) begin n_err++; $display("FAIL pf_level got=%0d exp=11", wlevel); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
`ifdef WPTR_LEVEL_EN
    test_prog_full();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and flag controller for the dual-clock FIFO, paired with the read-side empty/pointer logic. It runs entirely in the write clock domain and takes the read pointer after it has been synchronized into that domain. It produces the binary memory write address and the Gray-coded write pointer, which is exported for synchronization into the read domain. It also produces registered full and almost-full flags, a write enable, a sticky overflow flag and, optionally, an occupancy level.

## Interface
Parameters:
- ADDRSIZE, 4, memory address width; FIFO depth = 2**ADDRSIZE.
- PROG_FULL_THRESH, 12, level at or above which wprog_full asserts (only with level feature); legal range 1..2**ADDRSIZE.

Ports:
- wclk  in  1  write clock; the block's only clock.
- wrst  in  1  reset, synchronous, active-high.
- winc  in  1  write request from producer.
- wq2_rptr  in  ADDRSIZE+1  read Gray pointer, already 2-flop synchronized to wclk.
- wovf_clr  in  1  clears woverflow.
- wen  out  1  memory write enable = winc & ~wfull (combinational).
- waddr  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  registered Gray write pointer, to read-domain synchronizer.
- wfull  out  1  registered full.
- awfull  out  1  registered almost-full (exactly one free slot).
- woverflow  out  1  sticky: write attempted while full.
- wlevel  out  ADDRSIZE+1  registered occupancy (WPTR_LEVEL_EN only).
- wprog_full  out  1  registered wlevel >= PROG_FULL_THRESH (WPTR_LEVEL_EN only).

## Operation
- State: wbin (ADDRSIZE+1 binary), wptr (Gray), flags.
- wbinnext = wbin + wen; wgraynext = (wbinnext>>1) ^ wbinnext; registered together (GRAYSTYLE2).
- wgraynextp1 = Gray(wbinnext + 1), all arithmetic mod 2**(ADDRSIZE+1).
- Full compare: rfullcmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}.
- wfull <= (wgraynext == rfullcmp); awfull <= (wgraynextp1 == rfullcmp).
- Write while full (winc & wfull): no pointer movement; woverflow <= 1.
- woverflow: set has priority over a wovf_clr in the same cycle; clears otherwise.
- Level (macro): rbin_s = gray2bin(wq2_rptr); wlevel <= wbinnext - rbin_s, truncated to ADDRSIZE+1, range 0..2**ADDRSIZE; wprog_full <= (that value >= PROG_FULL_THRESH).
- Reset (wrst=1 at wclk edge): wbin=0, wptr=0, wfull=0, awfull=0, woverflow=0, wlevel=0, wprog_full=0. Reset overrides winc. A reset mid-stream discards pointer state; the read side must be reset coherently by the system.

## Timing
- wen/waddr are valid in the same cycle as winc; memory captures on that wclk edge.
- wptr, wfull and awfull update one cycle after the accepted write that causes the change.
- Full flag is pessimistic. It deasserts only after a read-side pointer advance arrives through the synchronizer (≥2 wclk plus rclk skew). It never deasserts early.
- Wrap-around: the MSB toggles every 2**ADDRSIZE writes. Full and empty are distinguished solely by the inverted top two Gray bits.
- When a write and a synchronized read update land in the same cycle, both are honored; flags are computed from wbinnext and the current wq2_rptr.

## Configuration
- WPTR_LEVEL_EN defined: wlevel and wprog_full ports, the gray2bin instance and their registers exist.
- Undefined: those ports and logic are absent; all other behavior is identical.

## Structure
- Shared package: ADDRSIZE default, Gray/binary conversion functions, depth constant.
- One sub-module, wptr_gray2bin: parameterized XOR-prefix Gray to binary converter, used for wq2_rptr.

## Test plan
- Reset: assert wrst with winc=1 → all outputs 0 next cycle, waddr=0.
- Fill: ADDRSIZE=4, wq2_rptr=0, 16 back-to-back writes → awfull=1 after write 15, wfull=1 after write 16, wptr=5'b11000, wlevel=16.
- Overflow: wfull=1, winc=1 → waddr unchanged, wen=0, woverflow=1. Then wovf_clr=1 together with winc=1 → woverflow stays 1. Then wovf_clr=1 with winc=0 → woverflow=0.
- Release: from full, drive wq2_rptr=Gray(1)=5'b00001 → wfull=0 and awfull=1 next cycle, wlevel=15.
- Wrap: 40 writes with wq2_rptr trailing by 3 entries → no spurious full, waddr sequence 0..15,0..15,0..7, wptr a valid Gray code (one-bit change per write).
- Prog-full (WPTR_LEVEL_EN, THRESH=12): the 12th write with wq2_rptr=0 → wprog_full=1 next cycle; one read release → wprog_full=0.
